// File: rtl/tt_um_islam_ihfaz_counter_ctrl.sv
// rtl/tt_um_islam_ihfaz_counter_ctrl.sv - programmable up/down tick counter with start/stop/pause control
//
// Ports:
//   clk      - single clock for all state
//   rst_n    - asynchronous active-low reset
//   ena      - power-good indication, not used by the logic
//   ui_in    - [0] start, [1] stop, [2] wr_lim_lo, [3] wr_lim_hi, [4] wr_presc,
//              [5] dir (0 up / 1 down), [6] auto_reload, [7] unused
//   uio_in   - [3:0] configuration data nibble, [7:4] unused
//   uo_out   - count[7:0]
//   uio_out  - [3:0] 0, [4] running, [5] done_pulse, [6] done_flag, [7] tick
//   uio_oe   - constant 8'hF0 (upper nibble of uio is output)

module tt_um_islam_ihfaz_counter_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [6:0] ui_s1;
    logic [6:0] ui_s2;
    logic [3:0] data_s1;
    logic [3:0] data_s2;
    logic [4:0] edge_prev;      // previous synchronized value of the strobe bits

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ui_s1     <= '0;
            ui_s2     <= '0;
            data_s1   <= '0;
            data_s2   <= '0;
            edge_prev <= '0;
        end else begin
            ui_s1     <= ui_in[6:0];
            ui_s2     <= ui_s1;
            data_s1   <= uio_in[3:0];
            data_s2   <= data_s1;
            edge_prev <= ui_s2[4:0];
        end
    end

    // Rising-edge pulses are combinational off the second sync stage, so an
    // input rise captured at edge k is acted on at edge k+2.
    logic [4:0] rise;
    assign rise = ui_s2[4:0] & ~edge_prev;

    logic start_p;
    logic stop_p;
    logic wr_lim_lo_p;
    logic wr_lim_hi_p;
    logic wr_presc_p;
    logic dir;
    logic auto_reload;

    assign start_p     = rise[0];
    assign stop_p      = rise[1];
    assign wr_lim_lo_p = rise[2];
    assign wr_lim_hi_p = rise[3];
    assign wr_presc_p  = rise[4];
    assign dir         = ui_s2[5];
    assign auto_reload = ui_s2[6];

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t     state;
    state_t     state_n;
    logic [7:0] count;
    logic [7:0] count_n;
    logic [7:0] limit;
    logic [7:0] limit_n;
    logic [3:0] presc;
    logic [3:0] presc_n;
    logic [3:0] pcnt;
    logic [3:0] pcnt_n;
    logic       tick;
    logic       done_ev;

    logic       running_q;
    logic       done_pulse_q;
    logic       done_flag_q;
    logic       tick_q;

    // Terminal and reload values follow dir as sampled now, so a direction
    // change mid-run takes effect at the next tick without reloading count.
    logic [7:0] terminal;
    logic [7:0] reload;
    assign terminal = dir ? 8'h00 : limit;
    assign reload   = dir ? limit : 8'h00;

    always_comb begin
        state_n = state;
        count_n = count;
        limit_n = limit;
        presc_n = presc;
        pcnt_n  = pcnt;
        tick    = 1'b0;
        done_ev = 1'b0;

        // Configuration writes are accepted whenever the counter is not running.
        if (state != RUN) begin
            if (wr_lim_lo_p) limit_n[3:0] = data_s2;
            if (wr_lim_hi_p) limit_n[7:4] = data_s2;
            if (wr_presc_p)  presc_n      = data_s2;
        end

        case (state)
            IDLE: begin
                // stop outranks start; in IDLE a stop simply keeps us here
                if (!stop_p && start_p) begin
                    state_n = RUN;
                    count_n = reload;
                    pcnt_n  = 4'd0;
                end
            end

            RUN: begin
                if (stop_p) begin
                    // Pausing freezes both count and prescaler phase, even if
                    // a tick would have fired on this edge.
                    state_n = PAUSED;
                end else if (pcnt == presc) begin
                    tick   = 1'b1;
                    pcnt_n = 4'd0;
                    if (count == terminal) begin
                        done_ev = 1'b1;
                        if (auto_reload) begin
                            count_n = reload;
                        end else begin
                            state_n = DONE;
                        end
                    end else begin
                        count_n = dir ? (count - 8'd1) : (count + 8'd1);
                    end
                end else begin
                    pcnt_n = pcnt + 4'd1;
                end
            end

            PAUSED: begin
                if (stop_p) begin
                    state_n = IDLE;
                    count_n = 8'h00;
                    pcnt_n  = 4'd0;
                end else if (start_p) begin
                    state_n = RUN;          // resume without reload
                end
            end

            DONE: begin
                if (stop_p) begin
                    state_n = IDLE;
                    count_n = 8'h00;
                    pcnt_n  = 4'd0;
                end else if (start_p) begin
                    state_n = RUN;
                    count_n = reload;
                    pcnt_n  = 4'd0;
                end
            end

            default: begin
                state_n = IDLE;
                count_n = 8'h00;
                pcnt_n  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= 8'h00;
            limit <= 8'h0F;
            presc <= 4'd0;
            pcnt  <= 4'd0;
        end else begin
            state <= state_n;
            count <= count_n;
            limit <= limit_n;
            presc <= presc_n;
            pcnt  <= pcnt_n;
        end
    end

    // Status outputs are registered from next-state values so they line up
    // with the count value produced on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q    <= 1'b0;
            done_pulse_q <= 1'b0;
            done_flag_q  <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            running_q    <= (state_n == RUN);
            done_pulse_q <= done_ev;
            done_flag_q  <= (state_n == DONE);
            tick_q       <= tick;
        end
    end

    assign uo_out  = count;
    assign uio_out = {tick_q, done_flag_q, done_pulse_q, running_q, 4'b0000};
    assign uio_oe  = 8'hF0;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, ui_in[7], uio_in[7:4]};

endmodule

// File: tb/tb_tt_um_islam_ihfaz_counter_ctrl.sv
// tb/tb_tt_um_islam_ihfaz_counter_ctrl.sv - scoreboard bench for the tick counter controller

module tb_tt_um_islam_ihfaz_counter_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    tt_um_islam_ihfaz_counter_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] cnt;
        logic       done;
        int         gap;    // clocks since previous tick / run entry, 0 = unchecked
    } exp_t;

    exp_t exp_q[$];
    int   n_chk;
    int   n_err;

    localparam int B_START = 0;
    localparam int B_STOP  = 1;
    localparam int B_LO    = 2;
    localparam int B_HI    = 3;
    localparam int B_PRE   = 4;
    localparam int B_DIR   = 5;
    localparam int B_AUTO  = 6;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push(input int c, input int d, input int g);
        exp_t e;
        e.cnt  = 8'(c);
        e.done = d[0];
        e.gap  = g;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse(input int b);
        ui_in[b] = 1'b1;
        step();
        ui_in[b] = 1'b0;
    endtask

    task automatic wr(input int b, input logic [3:0] d);
        uio_in = {4'h0, d};
        pulse(b);
        repeat (3) step();
    endtask

    task automatic wait_bit(input int b, input int bound, input string name);
        int n = 0;
        while (!uio_out[b] && n < bound) begin
            step();
            n++;
        end
        chk(name, int'(uio_out[b]), 1);
    endtask

    task automatic wait_drain(input int bound, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            step();
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_count"}, int'(uo_out), 0);
        chk({name, "_status"}, int'(uio_out), 0);
    endtask

    // Pops one expectation for every tick the DUT presents.
    task automatic monitor();
        int   cyc = 0;
        int   mark = 0;
        logic prev_run = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_run = 1'b0;
                mark     = cyc;
            end else begin
                if (uio_out[4] && !prev_run) mark = cyc;
                prev_run = uio_out[4];
                if (uio_out[7]) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_tick: got count %0d, expected no tick", uo_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tick_count", int'(uo_out), int'(e.cnt));
                        chk("tick_done_pulse", int'(uio_out[5]), int'(e.done));
                        if (e.gap != 0) chk("tick_gap", cyc - mark, e.gap);
                    end
                    mark = cyc;
                end else begin
                    chk("stray_done_pulse", int'(uio_out[5]), 0);
                end
            end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        fork
            monitor();
        join_none

        #1;
        chk("reset_count", int'(uo_out), 0);
        chk("reset_status", int'(uio_out), 0);
        chk("reset_oe", int'(uio_oe), 8'hF0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Up count to 5, presc 0, no reload
        wr(B_LO, 4'h5);
        for (int i = 1; i <= 5; i++) push(i, 0, 1);
        push(5, 1, 1);
        pulse(B_START);
        wait_bit(4, 10, "t1_running");
        chk("t1_load", int'(uo_out), 0);
        wait_bit(6, 30, "t1_done_flag");
        chk("t1_final", int'(uo_out), 5);
        chk("t1_running_off", int'(uio_out[4]), 0);
        repeat (3) step();
        chk("t1_hold", int'(uo_out), 5);

        // DONE -> stop -> IDLE; down, auto reload, limit 3, presc 2
        pulse(B_STOP);
        repeat (4) step();
        chk_idle("t2_idle");
        wr(B_LO, 4'h3);
        wr(B_HI, 4'h0);
        wr(B_PRE, 4'h2);
        ui_in[B_DIR]  = 1'b1;
        ui_in[B_AUTO] = 1'b1;
        repeat (3) step();
        for (int r = 0; r < 2; r++) begin
            push(2, 0, 3);
            push(1, 0, 3);
            push(0, 0, 3);
            push(3, 1, 3);
        end
        pulse(B_START);
        wait_bit(4, 10, "t2_running");
        chk("t2_load", int'(uo_out), 3);
        wait_drain(60, "t2_drain");
        chk("t2_still_running", int'(uio_out[4]), 1);
        pulse(B_STOP);              // lands on the next tick edge
        repeat (4) step();
        chk("t2_paused_count", int'(uo_out), 3);
        pulse(B_STOP);
        repeat (4) step();
        chk_idle("t2_idle_after");

        // Pause/resume in up mode, limit 5, presc 2
        ui_in[B_DIR]  = 1'b0;
        ui_in[B_AUTO] = 1'b0;
        wr(B_LO, 4'h5);
        push(1, 0, 3);
        push(2, 0, 3);
        pulse(B_START);
        wait_drain(20, "t3_drain_a");
        pulse(B_STOP);
        repeat (10) step();
        chk("t3_paused_count", int'(uo_out), 2);
        chk("t3_paused_running", int'(uio_out[4]), 0);
        chk("t3_paused_done", int'(uio_out[6]), 0);
        push(3, 0, 1);              // prescaler phase preserved: tick right after resume
        pulse(B_START);
        wait_bit(4, 10, "t3_resumed");
        wait_drain(20, "t3_drain_b");
        pulse(B_STOP);
        repeat (4) step();
        chk("t3_paused2_count", int'(uo_out), 3);
        pulse(B_STOP);
        repeat (4) step();
        chk_idle("t3_idle");

        // start and stop together from IDLE; write during RUN ignored
        ui_in[B_START] = 1'b1;
        ui_in[B_STOP]  = 1'b1;
        step();
        ui_in[B_START] = 1'b0;
        ui_in[B_STOP]  = 1'b0;
        repeat (5) step();
        chk_idle("t4_idle");
        wr(B_LO, 4'h2);
        wr(B_PRE, 4'h3);
        push(1, 0, 4);
        push(2, 0, 4);
        push(2, 1, 4);
        pulse(B_START);
        wait_bit(4, 10, "t4_running");
        wr(B_HI, 4'hA);
        wait_bit(6, 40, "t4_done_flag");
        chk("t4_final", int'(uo_out), 2);

        // limit 0: done on first tick
        pulse(B_STOP);
        repeat (4) step();
        wr(B_LO, 4'h0);
        wr(B_PRE, 4'h0);
        push(0, 1, 1);
        pulse(B_START);
        wait_bit(6, 20, "t5_done_flag");
        chk("t5_zero", int'(uo_out), 0);

        // limit 255: full run, no wrap
        pulse(B_STOP);
        repeat (4) step();
        wr(B_LO, 4'hF);
        wr(B_HI, 4'hF);
        for (int i = 1; i <= 255; i++) push(i, 0, 1);
        push(255, 1, 1);
        pulse(B_START);
        wait_bit(6, 300, "t5_done_ff");
        chk("t5_ff_final", int'(uo_out), 255);
        repeat (5) step();
        chk("t5_ff_hold", int'(uo_out), 255);
        chk("t5_ff_flag", int'(uio_out[6]), 1);

        // asynchronous reset mid-run
        pulse(B_STOP);
        repeat (4) step();
        wr(B_PRE, 4'hF);
        ui_in[B_DIR] = 1'b1;
        repeat (3) step();
        pulse(B_START);
        wait_bit(4, 10, "t6_running");
        chk("t6_load", int'(uo_out), 255);
        repeat (3) step();
        #1;
        rst_n = 1'b0;
        ui_in = 8'h00;
        #1;
        chk("t6_async_count", int'(uo_out), 0);
        chk("t6_async_status", int'(uio_out), 0);
        chk("t6_oe", int'(uio_oe), 8'hF0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        // default limit 8'h0F and presc 0 after reset
        for (int i = 1; i <= 15; i++) push(i, 0, 1);
        push(15, 1, 1);
        pulse(B_START);
        wait_bit(4, 10, "t6_running2");
        chk("t6_load2", int'(uo_out), 0);
        wait_bit(6, 40, "t6_done_flag");
        chk("t6_final", int'(uo_out), 15);
        chk("t6_oe_end", int'(uio_oe), 8'hF0);

        repeat (5) step();
        chk("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
